// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_op_sequencer: op and state encodings, the response bundle
// and the BCD correction constants used when ALU_DECIMAL_EN is defined.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADC = 3'd0,
    OP_SBC = 3'd1,
    OP_AND = 3'd2,
    OP_ORA = 3'd3,
    OP_EOR = 3'd4,
    OP_ASL = 3'd5,
    OP_LSR = 3'd6,
    OP_ROR = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_ADJUST = 3'd3,
    ST_RESP   = 3'd4
  } seq_state_e;

  typedef struct packed {
    logic [7:0] result;
    logic       c;
    logic       z;
    logic       v;
    logic       n;
  } alu_rsp_t;

  localparam logic [7:0] BCD_LO_ADJ    = 8'h06;
  localparam logic [7:0] BCD_HI_ADJ    = 8'h60;
  localparam logic [7:0] BCD_MAX       = 8'h99;
  localparam logic [3:0] BCD_DIGIT_MAX = 4'h9;

  function automatic logic is_arith(alu_op_e op);
    return (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_bcd_adjust.sv
// bcd_adjust: combinational NMOS-style decimal correction of a binary ADC/SBC result.
// Instantiated by alu_op_sequencer only when ALU_DECIMAL_EN is defined.
module bcd_adjust
  import alu_seq_pkg::*;
(
  input  alu_op_e    op,
  input  logic [7:0] bin_result,
  input  logic       bin_c,
  input  logic       half_c,
  output logic [7:0] adj_result,
  output logic       adj_c
);

  logic [7:0] lo_fixed;

  always_comb begin
    lo_fixed   = bin_result;
    adj_result = bin_result;
    adj_c      = bin_c;
    if (op == OP_SBC) begin
      // A missing half-carry or carry is a borrow out of that digit.
      if (!half_c) lo_fixed = bin_result - BCD_LO_ADJ;
      adj_result = bin_c ? lo_fixed : (lo_fixed - BCD_HI_ADJ);
      adj_c      = bin_c;
    end else begin
      if ((bin_result[3:0] > BCD_DIGIT_MAX) || half_c) lo_fixed = bin_result + BCD_LO_ADJ;
      if (bin_c || (bin_result > BCD_MAX)) begin
        adj_result = lo_fixed + BCD_HI_ADJ;
        adj_c      = 1'b1;
      end else begin
        adj_result = lo_fixed;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU request: load A/B registers, pulse the ALU function, hold the response.
// Define ALU_DECIMAL_EN to add the ADJUST state and BCD correction of ADC/SBC.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic       phi2,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_carry,
  input  logic       req_decimal,
  output logic [7:0] sb_drive,
  output logic [7:0] db_drive,
  output logic       a_systemBus_EN,
  output logic       b_dataBus_EN,
  output logic       b_dataBusInvert_EN,
  output logic       alu_sum_EN,
  output logic       alu_and_EN,
  output logic       alu_or_EN,
  output logic       alu_eor_EN,
  output logic       alu_shiftRight_EN,
  output logic       carry_FLAG_IN,
  input  logic [7:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       alu_v,
  input  logic       alu_n,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_c,
  output logic       rsp_z,
  output logic       rsp_v,
  output logic       rsp_n
);

  seq_state_e state_q, state_d;
  alu_op_e    op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       carry_q, carry_d;
  alu_rsp_t   rsp_q, rsp_d;
  logic       decimal_active;

`ifdef ALU_DECIMAL_EN
  logic       dec_q, dec_d;
  logic [3:0] b_lo;
  logic [4:0] lo_sum;
  logic [7:0] adj_result;
  logic       adj_c;

  assign decimal_active = dec_q;
  // Half-carry is rebuilt from the latched operands because the ALU does not export it.
  assign b_lo   = (op_q == OP_SBC) ? ~b_q[3:0] : b_q[3:0];
  assign lo_sum = {1'b0, a_q[3:0]} + {1'b0, b_lo} + {4'b0, carry_q};

  bcd_adjust u_bcd_adjust (
    .op         (op_q),
    .bin_result (rsp_q.result),
    .bin_c      (rsp_q.c),
    .half_c     (lo_sum[4]),
    .adj_result (adj_result),
    .adj_c      (adj_c)
  );
`else
  logic unused_decimal;
  assign decimal_active = 1'b0;
  assign unused_decimal = req_decimal;
`endif

  // NOTE: every combinational output gets a default before the case so no path infers a latch.
  always_comb begin
    state_d            = state_q;
    op_d               = op_q;
    a_d                = a_q;
    b_d                = b_q;
    carry_d            = carry_q;
    rsp_d              = rsp_q;
`ifdef ALU_DECIMAL_EN
    dec_d              = dec_q;
`endif
    req_ready          = 1'b0;
    rsp_valid          = 1'b0;
    sb_drive           = '0;
    db_drive           = '0;
    a_systemBus_EN     = 1'b0;
    b_dataBus_EN       = 1'b0;
    b_dataBusInvert_EN = 1'b0;
    alu_sum_EN         = 1'b0;
    alu_and_EN         = 1'b0;
    alu_or_EN          = 1'b0;
    alu_eor_EN         = 1'b0;
    alu_shiftRight_EN  = 1'b0;
    carry_FLAG_IN      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = alu_op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          carry_d = req_carry;
`ifdef ALU_DECIMAL_EN
          dec_d   = req_decimal;
`endif
          state_d = ST_LOAD;
        end
      end

      ST_LOAD, ST_EXEC: begin
        // Load strobes stay up through EXEC so the A/B registers keep their contents.
        sb_drive           = a_q;
        db_drive           = (op_q == OP_ASL) ? a_q : b_q;
        a_systemBus_EN     = 1'b1;
        b_dataBusInvert_EN = (op_q == OP_SBC);
        b_dataBus_EN       = (op_q != OP_SBC);
        if (state_q == ST_LOAD) begin
          state_d = ST_EXEC;
        end else begin
          case (op_q)
            OP_ADC, OP_SBC, OP_ASL: alu_sum_EN        = 1'b1;
            OP_AND:                 alu_and_EN        = 1'b1;
            OP_ORA:                 alu_or_EN         = 1'b1;
            OP_EOR:                 alu_eor_EN        = 1'b1;
            OP_LSR, OP_ROR:         alu_shiftRight_EN = 1'b1;
            default:                alu_sum_EN        = 1'b0;
          endcase
          carry_FLAG_IN = (is_arith(op_q) || (op_q == OP_ROR)) ? carry_q : 1'b0;
          rsp_d         = {alu_result, alu_c, alu_z, alu_v, alu_n};
          state_d       = (decimal_active && is_arith(op_q)) ? ST_ADJUST : ST_RESP;
        end
      end

`ifdef ALU_DECIMAL_EN
      ST_ADJUST: begin
        rsp_d.result = adj_result;
        rsp_d.c      = adj_c;
        state_d      = ST_RESP;
      end
`endif

      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge phi2) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADC;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      rsp_q   <= '0;
`ifdef ALU_DECIMAL_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      rsp_q   <= rsp_d;
`ifdef ALU_DECIMAL_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign rsp_result = rsp_q.result;
  assign rsp_c      = rsp_q.c;
  assign rsp_z      = rsp_q.z;
  assign rsp_v      = rsp_q.v;
  assign rsp_n      = rsp_q.n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: bench-side ALU, timeline/arithmetic model with a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_DECIMAL_EN
  localparam bit DEC_BUILD = 1'b1;
`else
  localparam bit DEC_BUILD = 1'b0;
`endif

  logic       phi2 = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid, req_ready;
  logic [2:0] req_op;
  logic [7:0] req_a, req_b;
  logic       req_carry, req_decimal;
  logic [7:0] sb_drive, db_drive;
  logic       a_systemBus_EN, b_dataBus_EN, b_dataBusInvert_EN;
  logic       alu_sum_EN, alu_and_EN, alu_or_EN, alu_eor_EN, alu_shiftRight_EN;
  logic       carry_FLAG_IN;
  logic [7:0] alu_result;
  logic       alu_c, alu_z, alu_v, alu_n;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_c, rsp_z, rsp_v, rsp_n;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 phi2 = ~phi2;

  alu_op_sequencer dut (
    .phi2               (phi2),
    .reset              (reset),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_op             (req_op),
    .req_a              (req_a),
    .req_b              (req_b),
    .req_carry          (req_carry),
    .req_decimal        (req_decimal),
    .sb_drive           (sb_drive),
    .db_drive           (db_drive),
    .a_systemBus_EN     (a_systemBus_EN),
    .b_dataBus_EN       (b_dataBus_EN),
    .b_dataBusInvert_EN (b_dataBusInvert_EN),
    .alu_sum_EN         (alu_sum_EN),
    .alu_and_EN         (alu_and_EN),
    .alu_or_EN          (alu_or_EN),
    .alu_eor_EN         (alu_eor_EN),
    .alu_shiftRight_EN  (alu_shiftRight_EN),
    .carry_FLAG_IN      (carry_FLAG_IN),
    .alu_result         (alu_result),
    .alu_c              (alu_c),
    .alu_z              (alu_z),
    .alu_v              (alu_v),
    .alu_n              (alu_n),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_result         (rsp_result),
    .rsp_c              (rsp_c),
    .rsp_z              (rsp_z),
    .rsp_v              (rsp_v),
    .rsp_n              (rsp_n)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Environment ALU: A/B registers loaded by the strobes, function picked by the enables.
  logic [7:0] alu_a_reg, alu_b_reg;
  logic [8:0] alu_s;
  always @(posedge phi2) begin
    if (a_systemBus_EN) alu_a_reg <= sb_drive;
    if (b_dataBus_EN) alu_b_reg <= db_drive;
    else if (b_dataBusInvert_EN) alu_b_reg <= ~db_drive;
  end
  assign alu_s = {1'b0, alu_a_reg} + {1'b0, alu_b_reg} + {8'b0, carry_FLAG_IN};
  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    if (alu_sum_EN) begin
      alu_result = alu_s[7:0];
      alu_c      = alu_s[8];
      alu_v      = (alu_a_reg[7] == alu_b_reg[7]) && (alu_s[7] != alu_a_reg[7]);
    end else if (alu_and_EN) alu_result = alu_a_reg & alu_b_reg;
    else if (alu_or_EN) alu_result = alu_a_reg | alu_b_reg;
    else if (alu_eor_EN) alu_result = alu_a_reg ^ alu_b_reg;
    else if (alu_shiftRight_EN) begin
      alu_result = {carry_FLAG_IN, alu_a_reg[7:1]};
      alu_c      = alu_a_reg[0];
    end
    alu_z = (alu_result == 8'h00);
    alu_n = alu_result[7];
  end

  // Expected response from plain arithmetic on the request.
  function automatic alu_rsp_t expect_rsp(alu_op_e op, logic [7:0] a, logic [7:0] b,
                                          logic c, logic d);
    alu_rsp_t r;
    int s, sv, da, db, ds;
    r = '0;
    case (op)
      OP_ADC: begin
        s  = int'(a) + int'(b) + int'(c);
        sv = int'($signed(a)) + int'($signed(b)) + int'(c);
        r.result = 8'(s);
        r.c = (s > 255);
        r.v = (sv > 127) || (sv < -128);
      end
      OP_SBC: begin
        s  = int'(a) - int'(b) - (1 - int'(c));
        sv = int'($signed(a)) - int'($signed(b)) - (1 - int'(c));
        r.result = 8'(s);
        r.c = (s >= 0);
        r.v = (sv > 127) || (sv < -128);
      end
      OP_AND: r.result = a & b;
      OP_ORA: r.result = a | b;
      OP_EOR: r.result = a ^ b;
      OP_ASL: begin r.result = 8'(int'(a) * 2); r.c = a[7]; r.v = a[7] ^ a[6]; end
      OP_LSR: begin r.result = 8'(int'(a) / 2); r.c = a[0]; end
      OP_ROR: begin r.result = 8'(int'(a) / 2 + (c ? 128 : 0)); r.c = a[0]; end
      default: r = '0;
    endcase
    r.z = (r.result == 8'h00);
    r.n = r.result[7];
    if (DEC_BUILD && d && (op == OP_ADC || op == OP_SBC)) begin
      da = int'(a[7:4]) * 10 + int'(a[3:0]);
      db = int'(b[7:4]) * 10 + int'(b[3:0]);
      if (op == OP_ADC) begin
        ds  = da + db + int'(c);
        r.c = (ds >= 100);
        ds  = ds % 100;
      end else begin
        ds  = da - db - (1 - int'(c));
        r.c = (ds >= 0);
        if (ds < 0) ds = ds + 100;
      end
      r.result = {4'(ds / 10), 4'(ds % 10)};
    end
    return r;
  endfunction

  // Timeline model: m_phase counts cycles since acceptance; response due at phase m_lat.
  logic     m_known = 1'b0;
  logic     m_busy = 1'b0;
  logic     m_after_reset = 1'b0;
  int       m_phase = 0;
  int       m_lat = 3;
  alu_op_e  m_op;
  logic [7:0] m_a, m_b;
  logic     m_c;
  alu_rsp_t m_exp;

  always @(posedge phi2) begin
    if (reset) begin
      m_known       <= 1'b1;
      m_busy        <= 1'b0;
      m_phase       <= 0;
      m_after_reset <= 1'b1;
    end else if (m_known) begin
      if (!m_busy) begin
        if (req_valid) begin
          m_busy        <= 1'b1;
          m_phase       <= 1;
          m_op          <= alu_op_e'(req_op);
          m_a           <= req_a;
          m_b           <= req_b;
          m_c           <= req_carry;
          m_exp         <= expect_rsp(alu_op_e'(req_op), req_a, req_b, req_carry, req_decimal);
          m_lat         <= (DEC_BUILD && req_decimal && (req_op <= 3'd1)) ? 4 : 3;
          m_after_reset <= 1'b0;
        end
      end else if (m_phase < m_lat) m_phase <= m_phase + 1;
      else if (rsp_ready) begin
        m_busy  <= 1'b0;
        m_phase <= 0;
      end
    end
  end

  always @(negedge phi2) begin
    logic [7:0] e_sb, e_db;
    logic [7:0] e_str;
    logic       e_cin;
    if (m_known) begin
      e_sb = '0; e_db = '0; e_str = '0; e_cin = 1'b0;
      if (m_busy && (m_phase == 1 || m_phase == 2)) begin
        e_sb = m_a;
        e_db = (m_op == OP_ASL) ? m_a : m_b;
        e_str[7] = 1'b1;
        e_str[6] = (m_op != OP_SBC);
        e_str[5] = (m_op == OP_SBC);
        if (m_phase == 2) begin
          e_str[4] = (m_op == OP_ADC || m_op == OP_SBC || m_op == OP_ASL);
          e_str[3] = (m_op == OP_AND);
          e_str[2] = (m_op == OP_ORA);
          e_str[1] = (m_op == OP_EOR);
          e_str[0] = (m_op == OP_LSR || m_op == OP_ROR);
          e_cin    = (m_op == OP_ADC || m_op == OP_SBC || m_op == OP_ROR) ? m_c : 1'b0;
        end
      end
      check("cyc_req_ready", 32'(req_ready), 32'(!m_busy));
      check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_phase == m_lat));
      check("cyc_drives", {16'h0, sb_drive, db_drive}, {16'h0, e_sb, e_db});
      check("cyc_strobes",
            {23'h0, a_systemBus_EN, b_dataBus_EN, b_dataBusInvert_EN, alu_sum_EN, alu_and_EN,
             alu_or_EN, alu_eor_EN, alu_shiftRight_EN, carry_FLAG_IN},
            {23'h0, e_str, e_cin});
      if (m_busy && m_phase == m_lat)
        check("cyc_rsp", {20'h0, rsp_result, rsp_c, rsp_z, rsp_v, rsp_n}, {20'h0, m_exp});
      else if (m_after_reset)
        check("cyc_rsp_reset", {20'h0, rsp_result, rsp_c, rsp_z, rsp_v, rsp_n}, 32'h0);
    end
  end

  // Cumulative strobe counters; the directed block takes differences around each op.
  int   sum_cnt = 0, inv_cnt = 0, bdb_cnt = 0;
  logic last_cin = 1'b0;
  always @(negedge phi2) begin
    sum_cnt <= sum_cnt + int'(alu_sum_EN);
    inv_cnt <= inv_cnt + int'(b_dataBusInvert_EN);
    bdb_cnt <= bdb_cnt + int'(b_dataBus_EN);
    if (alu_sum_EN | alu_and_EN | alu_or_EN | alu_eor_EN | alu_shiftRight_EN)
      last_cin <= carry_FLAG_IN;
  end

  // Entered and left at #1 after a rising edge with the DUT idle (unless keep is set).
  task automatic run(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic d, input int hold, input bit keep,
                     output alu_rsp_t got, output int lat);
    req_op = op; req_a = a; req_b = b; req_carry = c; req_decimal = d;
    req_valid = 1'b1;
    @(posedge phi2); #1;
    if (!keep) req_valid = 1'b0;
    else begin
      req_op = OP_AND; req_a = 8'hFF; req_b = 8'hFF;
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge phi2); #1;
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'h1);
    got = {rsp_result, rsp_c, rsp_z, rsp_v, rsp_n};
    for (int i = 0; i < hold; i++) begin
      @(posedge phi2); #1;
      check("hold_rsp_stable", {20'h0, rsp_result, rsp_c, rsp_z, rsp_v, rsp_n}, {20'h0, got});
      check("hold_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge phi2); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_rsp_t got;
    int lat, s0, i0, b0;
    req_valid = 1'b0; rsp_ready = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    req_carry = 1'b0; req_decimal = 1'b0;
    repeat (2) @(posedge phi2);
    #1 reset = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp", {20'h0, rsp_result, rsp_c, rsp_z, rsp_v, rsp_n}, 32'h0);

    s0 = sum_cnt;
    run(OP_ADC, 8'h50, 8'h50, 1'b0, 1'b0, 0, 1'b0, got, lat);
    check("adc_rsp", 32'(got), 32'({8'hA0, 1'b0, 1'b0, 1'b1, 1'b1}));
    check("adc_latency", 32'(lat), 32'd3);
    check("adc_sum_en_cycles", 32'(sum_cnt - s0), 32'd1);

    i0 = inv_cnt; b0 = bdb_cnt;
    run(OP_SBC, 8'h00, 8'h01, 1'b1, 1'b0, 0, 1'b0, got, lat);
    check("sbc_rsp", 32'(got), 32'({8'hFF, 1'b0, 1'b0, 1'b0, 1'b1}));
    check("sbc_invert_cycles", 32'(inv_cnt - i0), 32'd2);
    check("sbc_plain_b_cycles", 32'(bdb_cnt - b0), 32'd0);

    run(OP_LSR, 8'h81, 8'h00, 1'b1, 1'b0, 0, 1'b0, got, lat);
    check("lsr_rsp", 32'(got), 32'({8'h40, 1'b1, 1'b0, 1'b0, 1'b0}));
    check("lsr_carry_in", 32'(last_cin), 32'h0);

    run(OP_ROR, 8'h01, 8'h00, 1'b1, 1'b0, 0, 1'b0, got, lat);
    check("ror_rsp", 32'(got), 32'({8'h80, 1'b1, 1'b0, 1'b0, 1'b1}));
    check("ror_carry_in", 32'(last_cin), 32'h1);

    run(OP_ADC, 8'h58, 8'h46, 1'b1, 1'b1, 0, 1'b0, got, lat);
    if (DEC_BUILD) begin
      check("dec_adc_rsp", 32'(got), 32'({8'h05, 1'b1, 1'b0, 1'b1, 1'b1}));
      check("dec_adc_latency", 32'(lat), 32'd4);
    end else begin
      check("dec_adc_rsp", 32'(got), 32'({8'h9F, 1'b0, 1'b0, 1'b1, 1'b1}));
      check("dec_adc_latency", 32'(lat), 32'd3);
    end

    run(OP_SBC, 8'h25, 8'h50, 1'b1, 1'b1, 0, 1'b0, got, lat);
    if (DEC_BUILD) check("dec_sbc_rsp", 32'(got), 32'({8'h75, 1'b0, 1'b0, 1'b0, 1'b1}));
    else check("dec_sbc_rsp", 32'(got), 32'({8'hD5, 1'b0, 1'b0, 1'b0, 1'b1}));

    run(OP_AND, 8'hF0, 8'h0F, 1'b1, 1'b0, 0, 1'b0, got, lat);
    check("and_zero_rsp", 32'(got), 32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));

    run(OP_ASL, 8'hC0, 8'h00, 1'b1, 1'b0, 0, 1'b0, got, lat);
    check("asl_rsp", 32'(got), 32'({8'h80, 1'b1, 1'b0, 1'b0, 1'b1}));

    // Back-pressure with req_valid held high; next request must land on the first idle cycle.
    run(OP_ORA, 8'h12, 8'h40, 1'b0, 1'b0, 5, 1'b1, got, lat);
    check("ora_held_rsp", 32'(got), 32'({8'h52, 1'b0, 1'b0, 1'b0, 1'b0}));
    check("idle_after_handshake", 32'(req_ready), 32'h1);
    run(OP_EOR, 8'hFF, 8'h0F, 1'b0, 1'b0, 0, 1'b0, got, lat);
    check("eor_rsp", 32'(got), 32'({8'hF0, 1'b0, 1'b0, 1'b0, 1'b1}));
    check("eor_latency", 32'(lat), 32'd3);

    // Reset while in EXEC discards the operation.
    req_op = OP_ADC; req_a = 8'h11; req_b = 8'h22; req_carry = 1'b0; req_decimal = 1'b0;
    req_valid = 1'b1;
    @(posedge phi2); #1;
    req_valid = 1'b0;
    @(posedge phi2); #1;
    check("abort_in_exec", 32'(alu_sum_EN), 32'h1);
    reset = 1'b1;
    @(posedge phi2); #1;
    reset = 1'b0;
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_strobes",
          {23'h0, a_systemBus_EN, b_dataBus_EN, b_dataBusInvert_EN, alu_sum_EN, alu_and_EN,
           alu_or_EN, alu_eor_EN, alu_shiftRight_EN, carry_FLAG_IN}, 32'h0);
    check("abort_rsp_result", 32'(rsp_result), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge phi2); #1;
      check("abort_no_rsp", 32'(rsp_valid), 32'h0);
    end

    run(OP_ADC, 8'h01, 8'h01, 1'b1, 1'b0, 0, 1'b0, got, lat);
    check("post_abort_rsp", 32'(got), 32'({8'h03, 1'b0, 1'b0, 1'b0, 1'b0}));

    @(negedge phi2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Upstream control stage for the A/B input registers, the ALU and the ADD hold register.
- Accepts one arithmetic/logic request over a valid/ready handshake and drives the operands onto the system and data busses.
- Pulses the register-load and ALU-function enables in order, then captures the ALU result and flags into a response held until consumed.
- Optionally applies NMOS-style BCD correction to ADC/SBC.

## Interface
Parameters:
- none; all widths fixed at 8 bits, op encoding from shared package.

Ports:
- phi2  in  1  sole clock, all state updates on rising edge; reset is synchronous and active-high
- reset  in  1  synchronous, active-high; returns block to IDLE
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  3  ADC=0 SBC=1 AND=2 ORA=3 EOR=4 ASL=5 LSR=6 ROR=7
- req_a  in  8  operand A (accumulator side)
- req_b  in  8  operand B (memory side; ignored for ASL/LSR/ROR)
- req_carry  in  1  incoming C flag
- req_decimal  in  1  D flag; honoured only with decimal build
- sb_drive  out  8  value for systemBus
- db_drive  out  8  value for dataBus
- a_systemBus_EN, b_dataBus_EN, b_dataBusInvert_EN  out  1 each  register load strobes
- alu_sum_EN, alu_and_EN, alu_or_EN, alu_eor_EN, alu_shiftRight_EN  out  1 each  one-hot ALU function
- carry_FLAG_IN  out  1  ALU carry input
- alu_result  in  8  ALU hold value
- alu_c, alu_z, alu_v, alu_n  in  1 each  ALU flag outputs
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_result  out  8  final result
- rsp_c, rsp_z, rsp_v, rsp_n  out  1 each  final flags

## Operation
- States: IDLE, LOAD, EXEC, ADJUST (decimal build only), RESP.
- IDLE: req_ready=1. On req_valid, latch op/operands/carry/decimal, then go to LOAD.
- LOAD (1 cycle):
  - sb_drive = A.
  - a_systemBus_EN=1.
  - Load B from db_drive: b_dataBus_EN=1, or b_dataBusInvert_EN=1 for SBC.
  - db_drive = B, or A for ASL; don't-care otherwise, held at latched B.
- EXEC (1 cycle): exactly one ALU enable high; load strobes stay high so register contents persist.
  - ADC/SBC/ASL → sum.
  - AND → and; ORA → or; EOR → eor.
  - LSR/ROR → shiftRight.
- carry_FLAG_IN in EXEC:
  - latched carry for ADC/SBC/ROR.
  - 0 for ASL/LSR.
  - don't-care, driven 0, for logic ops.
- On the EXEC→next edge, capture alu_result and the four ALU flags.
- Logic ops report ALU C/V as-is; the consumer masks unaffected flags.
- EXEC goes to RESP, or to ADJUST when ADC/SBC with decimal active.
- RESP: rsp_valid=1 with rsp_* stable. Return to IDLE on the edge where rsp_ready=1.
- All strobes are 0 outside LOAD/EXEC.
- Drives are 0 outside LOAD/EXEC.

## Timing
- Acceptance edge t0 → LOAD in cycle t0+1 → EXEC in t0+2 → rsp_valid first high in cycle t0+3.
- Decimal ADC/SBC: rsp_valid first high in t0+4.
- Minimum request spacing is 4 cycles (5 decimal); a request cannot be accepted in the same cycle a response is consumed.
- rsp_valid held with constant data under rsp_ready=0 for any length.
- Reset, at any state and cycle: next state IDLE.
  - Reset values: req_ready=1, rsp_valid=0, rsp_result=0, all rsp flags 0, all strobes/drives 0.
  - In-flight op discarded.
- req_valid while not in IDLE: ignored (req_ready=0).

## Configuration
- ALU_DECIMAL_EN defined:
  - ADJUST state and BCD logic present.
  - Half-carry is computed locally from latched A low nibble plus (B or ~B) low nibble plus carry.
  - ADC: add 6 if low nibble >9 or half-carry. Add 0x60 and set C if binary carry or value >0x99.
  - SBC: subtract 6 if no half-carry; subtract 0x60 if ALU C=0; C = ALU C.
  - N, V, Z come from the binary result in both cases.
- ALU_DECIMAL_EN undefined:
  - req_decimal ignored, no ADJUST state, binary results only.

## Structure
- Shared package alu_seq_pkg holds:
  - op enum;
  - state enum;
  - BCD constants 6/0x60/0x99.
- Sub-module bcd_adjust is combinational: binary result, carries and op in; corrected result and C out. It is instantiated only under ALU_DECIMAL_EN.

## Test plan
- ADC A=0x50 B=0x50 C=0 → result 0xA0, N=1 V=1 C=0 Z=0. rsp_valid 3 cycles after accept. alu_sum_EN high exactly one cycle.
- SBC A=0x00 B=0x01 C=1 → b_dataBusInvert_EN pulses in LOAD; result 0xFF, N=1 C=0 Z=0.
- LSR A=0x81 → 0x40, C=1. ROR A=0x01 C=1 → 0x80, C=1 N=1. carry_FLAG_IN in EXEC is 0 then 1 respectively.
- Decimal ADC A=0x58 B=0x46 C=1 D=1 (macro on) → 0x05, C=1, latency 4. Macro off → 0x9F, C=0, latency 3.
- rsp_ready low 5 cycles with req_valid held high → rsp_* constant, req_ready=0. Accept on the first idle cycle after the handshake.
- Reset asserted during EXEC → next cycle IDLE, rsp_valid=0, all strobes 0. No response is ever emitted for the aborted op.
